// File: rtl/atm_session_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : atm_session_ctrl_pkg                                          |
// | Purpose  : Shared widths, authenticator status levels, error codes and   |
// |            controller state encoding for the ATM session controller.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package atm_session_ctrl_pkg;

  localparam int ACC_W = 4;   // account number / database index width
  localparam int PIN_W = 16;  // keypad PIN width
  localparam int TRY_W = 2;   // attempts_left width (MAX_TRIES is 1..3)
  localparam int ERR_W = 3;   // err_code width

  // Active levels of the authenticator status lines.
  localparam logic ACCOUNT_FOUND         = 1'b1;
  localparam logic ACCOUNT_AUTHENTICATED = 1'b1;

  localparam logic [ERR_W-1:0] ERR_NONE      = 3'd0;
  localparam logic [ERR_W-1:0] ERR_NOT_FOUND = 3'd1;
  localparam logic [ERR_W-1:0] ERR_BAD_PIN   = 3'd2;
  localparam logic [ERR_W-1:0] ERR_LOCKED    = 3'd3;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_WAIT_PIN = 3'd2,
    ST_CHECK    = 3'd3,
    ST_SESSION  = 3'd4,
    ST_EJECT    = 3'd5
  } state_t;

endpackage : atm_session_ctrl_pkg
`default_nettype wire

// File: rtl/atm_session_ctrl_session_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : atm_session_ctrl_session_timer                                |
// | Purpose  : Saturating inactivity down-counter shared by the PIN-entry    |
// |            and open-session phases.                                      |
// | Ports    : clk, rst_n  - clock, synchronous active-low reset             |
// |            load        - reload count with TIMEOUT_CYCLES (wins on tick) |
// |            tick        - decrement by one, saturating at zero            |
// |            expired     - count currently reads zero                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module atm_session_ctrl_session_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule : atm_session_ctrl_session_timer
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : atm_session_ctrl                                              |
// | Purpose  : Sequences one ATM card session around an external            |
// |            combinational authenticator: insert -> lookup -> PIN entry   |
// |            with retries -> session -> eject. Keeps a sticky per-account |
// |            lock bitmap and an inactivity timeout.                        |
// | Ports    : clk, rst_n           clock, synchronous active-low reset      |
// |            card_in, acc_num     card level and account number            |
// |            pin, pin_valid       keypad PIN and its strobe                |
// |            activity, logout     session strobes                          |
// |            auth_acc_num/pin     registered request to authenticator      |
// |            auth_acc_index/found/ok  authenticator response               |
// |            session_active/index open-session qualifier and index         |
// |            attempts_left        remaining PIN tries                      |
// |            err_valid/err_code   one-cycle error event                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module atm_session_ctrl
  import atm_session_ctrl_pkg::*;
#(
  parameter int NUM_ACCOUNTS   = 10,   // 1..16, index space of auth_acc_index
  parameter int MAX_TRIES      = 3,    // 1..3
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_in,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic             activity,
  input  logic             logout,
  output logic [ACC_W-1:0] auth_acc_num,
  output logic [PIN_W-1:0] auth_pin,
  input  logic [ACC_W-1:0] auth_acc_index,
  input  logic             auth_found,
  input  logic             auth_ok,
  output logic             session_active,
  output logic [ACC_W-1:0] session_index,
  output logic [TRY_W-1:0] attempts_left,
  output logic             err_valid,
  output logic [ERR_W-1:0] err_code
);

  localparam logic [TRY_W-1:0] TRIES_INIT = TRY_W'(MAX_TRIES);

  state_t state, state_nxt;

  logic [ACC_W-1:0]        acc_index, index_nxt;
  logic [ACC_W-1:0]        acc_num_nxt;
  logic [PIN_W-1:0]        pin_nxt;
  logic [TRY_W-1:0]        tries_nxt;
  logic                    err_valid_nxt;
  logic [ERR_W-1:0]        err_code_nxt;
  logic [NUM_ACCOUNTS-1:0] lock;
  logic [NUM_ACCOUNTS-1:0] lock_sel;
  logic                    lock_hit;
  logic                    lock_set;
  logic                    tmr_load, tmr_tick, tmr_expired;

  atm_session_ctrl_session_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_session_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  // Lock lookup uses the live authenticator index (LOOKUP); lock update uses
  // the index latched for this card (CHECK). Indices outside the bitmap never
  // hit and never set a bit.
  always_comb begin
    lock_hit = 1'b0;
    lock_sel = '0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (auth_acc_index == ACC_W'(i)) begin
        lock_hit = lock[i];
      end
      lock_sel[i] = (acc_index == ACC_W'(i));
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_num_nxt   = auth_acc_num;
    pin_nxt       = auth_pin;
    index_nxt     = acc_index;
    tries_nxt     = attempts_left;
    err_valid_nxt = 1'b0;
    err_code_nxt  = ERR_NONE;
    lock_set      = 1'b0;
    tmr_load      = 1'b0;
    tmr_tick      = 1'b0;

    if ((state != ST_IDLE) && !card_in) begin
      // Card pulled: silent abort, tries for this card forgotten.
      state_nxt = ST_IDLE;
      tries_nxt = TRIES_INIT;
      pin_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (card_in) begin
            acc_num_nxt = acc_num;
            state_nxt   = ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (auth_found != ACCOUNT_FOUND) begin
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_NOT_FOUND;
            pin_nxt       = '0;
            state_nxt     = ST_EJECT;
          end else if (lock_hit) begin
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_LOCKED;
            pin_nxt       = '0;
            state_nxt     = ST_EJECT;
          end else begin
            index_nxt = auth_acc_index;
            tries_nxt = TRIES_INIT;
            tmr_load  = 1'b1;
            state_nxt = ST_WAIT_PIN;
          end
        end

        ST_WAIT_PIN: begin
          // A PIN arriving on the expiry cycle still counts.
          if (pin_valid) begin
            pin_nxt   = pin;
            state_nxt = ST_CHECK;
          end else if (tmr_expired) begin
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_TIMEOUT;
            pin_nxt       = '0;
            state_nxt     = ST_EJECT;
          end else begin
            tmr_tick = 1'b1;
          end
        end

        ST_CHECK: begin
          if (auth_ok == ACCOUNT_AUTHENTICATED) begin
            tmr_load  = 1'b1;
            state_nxt = ST_SESSION;
          end else if (attempts_left <= TRY_W'(1)) begin
            tries_nxt     = '0;
            lock_set      = 1'b1;
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_LOCKED;
            pin_nxt       = '0;
            state_nxt     = ST_EJECT;
          end else begin
            tries_nxt     = attempts_left - TRY_W'(1);
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_BAD_PIN;
            tmr_load      = 1'b1;
            state_nxt     = ST_WAIT_PIN;
          end
        end

        ST_SESSION: begin
          if (logout) begin
            pin_nxt   = '0;
            state_nxt = ST_EJECT;
          end else if (tmr_expired) begin
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_TIMEOUT;
            pin_nxt       = '0;
            state_nxt     = ST_EJECT;
          end else if (activity) begin
            tmr_load = 1'b1;
          end else begin
            tmr_tick = 1'b1;
          end
        end

        ST_EJECT: begin
          pin_nxt = '0;
        end

        default: begin
          state_nxt = ST_IDLE;
          tries_nxt = TRIES_INIT;
          pin_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      auth_acc_num   <= '0;
      auth_pin       <= '0;
      acc_index      <= '0;
      attempts_left  <= TRIES_INIT;
      err_valid      <= 1'b0;
      err_code       <= ERR_NONE;
      session_active <= 1'b0;
      session_index  <= '0;
      lock           <= '0;
    end else begin
      state          <= state_nxt;
      auth_acc_num   <= acc_num_nxt;
      auth_pin       <= pin_nxt;
      acc_index      <= index_nxt;
      attempts_left  <= tries_nxt;
      err_valid      <= err_valid_nxt;
      err_code       <= err_code_nxt;
      // Session outputs follow the state being entered so they are registered
      // yet aligned with SESSION itself.
      session_active <= (state_nxt == ST_SESSION);
      session_index  <= (state_nxt == ST_SESSION) ? index_nxt : '0;
      if (lock_set) begin
        lock <= lock | lock_sel;
      end
    end
  end

endmodule : atm_session_ctrl
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_atm_session_ctrl                                           |
// | Purpose  : Self-checking bench for atm_session_ctrl with a behavioural   |
// |            authenticator (accounts 1..10 -> index acc-1,                 |
// |            PIN = 1111*acc+123) and a cycle model compared every cycle.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_atm_session_ctrl;
  import atm_session_ctrl_pkg::*;

  localparam int T    = 16;
  localparam int NACC = 10;
  localparam int MAXT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        card_in = 1'b0;
  logic [3:0]  acc_num = '0;
  logic [15:0] pin = '0;
  logic        pin_valid = 1'b0;
  logic        activity = 1'b0;
  logic        logout = 1'b0;
  logic [3:0]  auth_acc_num;
  logic [15:0] auth_pin;
  logic [3:0]  auth_acc_index;
  logic        auth_found;
  logic        auth_ok;
  logic        session_active;
  logic [3:0]  session_index;
  logic [1:0]  attempts_left;
  logic        err_valid;
  logic [2:0]  err_code;

  atm_session_ctrl #(
    .NUM_ACCOUNTS   (NACC),
    .MAX_TRIES      (MAXT),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .card_in        (card_in),
    .acc_num        (acc_num),
    .pin            (pin),
    .pin_valid      (pin_valid),
    .activity       (activity),
    .logout         (logout),
    .auth_acc_num   (auth_acc_num),
    .auth_pin       (auth_pin),
    .auth_acc_index (auth_acc_index),
    .auth_found     (auth_found),
    .auth_ok        (auth_ok),
    .session_active (session_active),
    .session_index  (session_index),
    .attempts_left  (attempts_left),
    .err_valid      (err_valid),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pin_of(input logic [3:0] a);
    return 16'(1111 * int'(a) + 123);
  endfunction

  function automatic bit acc_exists(input logic [3:0] a);
    return (a >= 4'd1) && (int'(a) <= NACC);
  endfunction

  // Authenticator stand-in.
  always_comb begin
    auth_found     = acc_exists(auth_acc_num);
    auth_acc_index = auth_found ? (auth_acc_num - 4'd1) : 4'd0;
    auth_ok        = auth_found && (auth_pin == pin_of(auth_acc_num));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_LOOKUP = 1, P_WAIT = 2, P_CHECK = 3, P_SESSION = 4, P_EJECT = 5;

  int          m_phase = P_IDLE;
  logic [3:0]  m_acc = '0;
  logic [15:0] m_pin = '0;
  int          m_tries = MAXT;
  int          m_idle = 0;      // cycles since last timer (re)start
  bit          m_lock[16];      // by account number
  bit          m_err_v = 1'b0;
  int          m_err_c = 0;
  bit          m_act = 1'b0;
  int          m_sidx = 0;

  always @(posedge clk) begin
    m_err_v = 1'b0;
    m_err_c = 0;
    if (!rst_n) begin
      m_phase = P_IDLE; m_acc = '0; m_pin = '0; m_tries = MAXT; m_idle = 0;
      for (int i = 0; i < 16; i++) m_lock[i] = 1'b0;
    end else if (m_phase != P_IDLE && !card_in) begin
      m_phase = P_IDLE; m_tries = MAXT; m_pin = '0;
    end else begin
      case (m_phase)
        P_IDLE: if (card_in) begin m_acc = acc_num; m_phase = P_LOOKUP; end
        P_LOOKUP: begin
          if (!acc_exists(m_acc)) begin m_err_v = 1; m_err_c = 1; m_phase = P_EJECT; end
          else if (m_lock[m_acc]) begin m_err_v = 1; m_err_c = 3; m_phase = P_EJECT; end
          else begin m_tries = MAXT; m_idle = 0; m_phase = P_WAIT; end
        end
        P_WAIT: begin
          if (pin_valid) begin m_pin = pin; m_phase = P_CHECK; end
          else if (m_idle == T) begin m_err_v = 1; m_err_c = 4; m_pin = '0; m_phase = P_EJECT; end
          else m_idle++;
        end
        P_CHECK: begin
          if (m_pin == pin_of(m_acc)) begin m_idle = 0; m_phase = P_SESSION; end
          else begin
            m_tries--;
            if (m_tries == 0) begin
              m_lock[m_acc] = 1; m_err_v = 1; m_err_c = 3; m_pin = '0; m_phase = P_EJECT;
            end else begin
              m_err_v = 1; m_err_c = 2; m_idle = 0; m_phase = P_WAIT;
            end
          end
        end
        P_SESSION: begin
          if (logout) begin m_pin = '0; m_phase = P_EJECT; end
          else if (m_idle == T) begin m_err_v = 1; m_err_c = 4; m_pin = '0; m_phase = P_EJECT; end
          else if (activity) m_idle = 0;
          else m_idle++;
        end
        default: ;
      endcase
    end
    m_act  = (m_phase == P_SESSION);
    m_sidx = m_act ? int'(m_acc) - 1 : 0;
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_session_active", session_active, m_act);
      chk("cmp_session_index", session_index, m_sidx);
      chk("cmp_attempts_left", attempts_left, m_tries);
      chk("cmp_err_valid", err_valid, m_err_v);
      chk("cmp_err_code", err_code, m_err_c);
      chk("cmp_auth_acc_num", auth_acc_num, m_acc);
      chk("cmp_auth_pin", auth_pin, m_pin);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic insert(input logic [3:0] a);
    acc_num = a; card_in = 1'b1; cyc(1);
  endtask

  task automatic pulse_pin(input logic [15:0] p);
    pin = p; pin_valid = 1'b1; cyc(1); pin_valid = 1'b0;
  endtask

  task automatic remove();
    card_in = 1'b0; cyc(2);
  endtask

  task automatic wait_err(input string nm, input logic [2:0] code, input int budget,
                          output int waited);
    bit seen = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      cyc(1);
      waited++;
      if (err_valid) seen = 1'b1;
    end
    chk({nm, "_seen"}, int'(seen), 1);
    if (seen) chk({nm, "_code"}, err_code, code);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    cyc(2);
    cmp_en = 1'b1;
    cyc(1);
    chk("rst_attempts", attempts_left, 3);
    chk("rst_active", session_active, 0);
    chk("rst_err_valid", err_valid, 0);
    rst_n = 1'b1;
    cyc(1);

    // Good session on account 1, activity keep-alive, logout+activity.
    insert(4'd1); cyc(1);
    chk("a1_wait_attempts", attempts_left, 3);
    pulse_pin(16'd1234);
    chk("a1_active_n1", session_active, 0);
    cyc(1);
    chk("a1_active_n2", session_active, 1);
    chk("a1_index", session_index, 0);
    chk("a1_no_err", err_valid, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(9); activity = 1'b1; cyc(1); activity = 1'b0;
    end
    chk("a1_active_100", session_active, 1);
    logout = 1'b1; activity = 1'b1; cyc(1); logout = 1'b0; activity = 1'b0;
    chk("a1_logout_active", session_active, 0);
    chk("a1_logout_no_err", err_valid, 0);
    chk("a1_logout_pin_clr", auth_pin, 0);
    remove();

    // Three wrong PINs on account 3 -> lock.
    insert(4'd3); cyc(1);
    pulse_pin(16'd1111);
    wait_err("a3_bad1", ERR_BAD_PIN, 3, w);
    chk("a3_attempts_2", attempts_left, 2);
    pulse_pin(16'd2222);
    wait_err("a3_bad2", ERR_BAD_PIN, 3, w);
    chk("a3_attempts_1", attempts_left, 1);
    pulse_pin(16'd3333);
    wait_err("a3_lock", ERR_LOCKED, 3, w);
    chk("a3_attempts_0", attempts_left, 0);
    cyc(3);
    remove();
    insert(4'd3);
    wait_err("a3_relock", ERR_LOCKED, 2, w);
    chk("a3_relock_lat", w, 1);
    pulse_pin(16'd3456); cyc(2);
    chk("a3_relock_inactive", session_active, 0);
    remove();

    // Unknown account.
    insert(4'd12);
    wait_err("a12_notfound", ERR_NOT_FOUND, 3, w);
    chk("a12_latency", w, 1);
    cyc(5);
    chk("a12_eject_inactive", session_active, 0);
    chk("a12_single_pulse", err_valid, 0);
    remove();

    // PIN-entry timeout, then PIN accepted on the expiry cycle.
    insert(4'd2); cyc(1);
    wait_err("a2_timeout", ERR_TIMEOUT, 25, w);
    chk("a2_timeout_lat", w, T + 1);
    remove();
    insert(4'd2); cyc(1); cyc(T);
    pulse_pin(16'd2345);
    chk("a2_expiry_pin_no_err", err_valid, 0);
    cyc(1);
    chk("a2_expiry_pin_active", session_active, 1);
    chk("a2_index", session_index, 1);

    // Reset mid-session clears everything including the lock bitmap.
    rst_n = 1'b0; cyc(1);
    chk("rst_mid_active", session_active, 0);
    chk("rst_mid_index", session_index, 0);
    chk("rst_mid_attempts", attempts_left, 3);
    chk("rst_mid_pin", auth_pin, 0);
    card_in = 1'b0; cyc(1);
    rst_n = 1'b1; cyc(1);
    insert(4'd3); cyc(1);
    chk("a3_unlocked_no_err", err_valid, 0);
    chk("a3_unlocked_attempts", attempts_left, 3);
    pulse_pin(16'd3456); cyc(1);
    chk("a3_unlocked_active", session_active, 1);
    chk("a3_unlocked_index", session_index, 2);
    remove();
    chk("a3_removed_inactive", session_active, 0);

    // Session inactivity timeout.
    insert(4'd1); cyc(1);
    pulse_pin(16'd1234); cyc(1);
    wait_err("a1_sess_timeout", ERR_TIMEOUT, 25, w);
    chk("a1_sess_timeout_lat", w, T + 1);
    chk("a1_sess_timeout_inactive", session_active, 0);
    remove();

    // Card removal in WAIT_PIN: silent return to idle.
    insert(4'd1); cyc(1);
    card_in = 1'b0; cyc(1);
    chk("rm_wait_no_err", err_valid, 0);
    chk("rm_wait_attempts", attempts_left, 3);
    cyc(3);
    pulse_pin(16'd1234); cyc(1);
    chk("idle_pin_ignored", auth_pin, 0);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_atm_session_ctrl
`default_nettype wire
